// File: rtl/dpd_loop_delay_est_pkg.sv
// Shared types and constants for the DPD loop-delay estimator.
// The search FSM walks one candidate lag per training burst.
package dpd_loop_delay_est_pkg;

   localparam int LAG_W = 8;
   localparam int CNT_W = 16;

   typedef logic signed [47:0] s48_t;
   typedef logic        [47:0] u48_t;

   localparam s48_t S48_MIN = {1'b1, 47'd0};

   typedef enum logic [2:0] {
      st_idle,
      st_req,
      st_run,
      st_cmp,
      st_gap,
      st_done
   } state_t;

endpackage

// File: rtl/dpd_loop_delay_est_tap_line.sv
// Free-running reference delay line; tap 0 is the live input so the tap index
// equals the delay in cycles with no extra latency.
module dpd_loop_delay_est_tap_line
   import dpd_loop_delay_est_pkg::*;
#(
   parameter int W = 40,
   parameter int D = 64
) (
   input  logic             clk,
   input  logic [LAG_W-1:0] sel,
   input  logic [W-1:0]     din,
   output logic [W-1:0]     tap
);

   logic [W-1:0] line [1:D-1];

   // Contents are deliberately not reset; the window never opens before the line is full.
   always_ff @(posedge clk) begin
      line[1] <= din;
      for (int k = 2; k < D; k++) begin
         line[k] <= line[k-1];
      end
   end

   always_comb begin
      tap = din;
      for (int k = 1; k < D; k++) begin
         if (int'(sel) == k) begin
            tap = line[k];
         end
      end
   end

endmodule

// File: rtl/dpd_loop_delay_est.sv
// Loop-delay estimator: serially cross-correlates the training reference against
// PA feedback, one lag per burst, and reports the best-aligned lag.
module dpd_loop_delay_est
   import dpd_loop_delay_est_pkg::*;
#(
   parameter int LAG_MIN   = 16,
   parameter int LAG_MAX   = 63,
   parameter int WIN_START = 128,
   parameter int WIN       = 512,
   parameter int GAP       = 256
) (
   input  logic               clk,
   input  logic               reset_b,
   input  logic               start,
   input  logic               abort,
   input  logic signed [19:0] ref_i,
   input  logic signed [19:0] ref_q,
   input  logic signed [19:0] fb_i,
   input  logic signed [19:0] fb_q,
   output logic               train_req,
   output logic               busy,
   output logic               done,
   output logic [LAG_W-1:0]   delay_out,
   output logic               delay_valid,
   output s48_t               peak_metric
);

   localparam logic [LAG_W-1:0] LAG_MIN_C = LAG_W'(LAG_MIN);
   localparam logic [LAG_W-1:0] LAG_MAX_C = LAG_W'(LAG_MAX);
   localparam logic [CNT_W-1:0] WIN_LO    = CNT_W'(WIN_START);
   localparam logic [CNT_W-1:0] RUN_END   = CNT_W'(WIN_START + WIN - 1);
   localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(GAP - 1);

   state_t             state;
   logic [LAG_W-1:0]   lag;
   logic [LAG_W-1:0]   best_lag;
   s48_t               best;
   s48_t               acc;
   logic [CNT_W-1:0]   cnt;

   logic [39:0]        tap;
   logic signed [19:0] ref_d_i;
   logic signed [19:0] ref_d_q;
   logic signed [39:0] prod_ii;
   logic signed [39:0] prod_qq;
   logic signed [40:0] prod;
   logic signed [40:0] prod_sh;
   s48_t               prod_ext;
   logic               in_win;

   dpd_loop_delay_est_tap_line #(
      .W (40),
      .D (LAG_MAX + 1)
   ) u_tap_line (
      .clk (clk),
      .sel (lag),
      .din ({ref_i, ref_q}),
      .tap (tap)
   );

   assign ref_d_i = tap[39:20];
   assign ref_d_q = tap[19:0];
   assign in_win  = (cnt >= WIN_LO) && (cnt <= RUN_END);

   // Full-precision complex-real correlation term, scaled down by 2^8 before accumulation.
   always_comb begin
      prod_ii  = ref_d_i * fb_i;
      prod_qq  = ref_d_q * fb_q;
      prod     = {prod_ii[39], prod_ii} + {prod_qq[39], prod_qq};
      prod_sh  = prod >>> 8;
      prod_ext = {{7{prod_sh[40]}}, prod_sh};
   end

   // Search sequencer; abort overrides everything, including a same-cycle start.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state       <= st_idle;
         lag         <= LAG_MIN_C;
         best_lag    <= LAG_MIN_C;
         best        <= S48_MIN;
         acc         <= '0;
         cnt         <= '0;
         train_req   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         delay_out   <= '0;
         delay_valid <= 1'b0;
         peak_metric <= '0;
      end else if (abort) begin
         state       <= st_idle;
         train_req   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         delay_valid <= 1'b0;
      end else begin
         train_req <= 1'b0;
         done      <= 1'b0;
         case (state)
            st_idle: begin
               if (start) begin
                  state       <= st_req;
                  lag         <= LAG_MIN_C;
                  best        <= S48_MIN;
                  best_lag    <= LAG_MIN_C;
                  delay_valid <= 1'b0;
                  busy        <= 1'b1;
                  train_req   <= 1'b1;
               end
            end
            st_req: begin
               cnt   <= '0;
               acc   <= '0;
               state <= st_run;
            end
            st_run: begin
               cnt <= cnt + 1'b1;
               if (in_win) begin
                  acc <= acc + prod_ext;
               end
               if (cnt == RUN_END) begin
                  state <= st_cmp;
               end
            end
            st_cmp: begin
               // Strict compare so ties keep the smaller lag already stored.
               if (acc > best) begin
                  best     <= acc;
                  best_lag <= lag;
               end
               cnt   <= '0;
               state <= st_gap;
            end
            st_gap: begin
               cnt <= cnt + 1'b1;
               if (cnt == GAP_END) begin
                  if (lag == LAG_MAX_C) begin
                     state       <= st_done;
                     done        <= 1'b1;
                     delay_out   <= best_lag;
                     peak_metric <= best;
                     delay_valid <= 1'b1;
                  end else begin
                     lag       <= lag + 1'b1;
                     state     <= st_req;
                     train_req <= 1'b1;
                  end
               end
            end
            st_done: begin
               state <= st_idle;
               busy  <= 1'b0;
            end
            default: begin
               state <= st_idle;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dpd_loop_delay_est.sv
// Self-checking bench: random QPSK reference, delayed feedback, and a plain
// correlation model that predicts the winning lag and its metric.
module tb_dpd_loop_delay_est;

   localparam int LAG_MIN = 16;
   localparam int LAG_MAX = 63;
   localparam int WS      = 64;
   localparam int WN      = 32;
   localparam int GP      = 8;
   localparam int NLAG    = LAG_MAX - LAG_MIN + 1;
   localparam int PER     = 1 + WS + WN + 1 + GP;
   localparam int HIST    = 65536;
   localparam int AMP     = 1 << 18;

   logic               clk = 1'b0;
   logic               reset_b;
   logic               start;
   logic               abort;
   logic signed [19:0] ref_i, ref_q, fb_i, fb_q;
   logic               train_req, busy, done, delay_valid;
   logic [7:0]         delay_out;
   logic signed [47:0] peak_metric;

   int errors    = 0;
   int checks    = 0;
   int edge_cnt  = 0;
   int gen_delay = 41;
   int treq_cnt  = 0;
   int ri_h [0:HIST-1];
   int rq_h [0:HIST-1];
   int fi_h [0:HIST-1];
   int fq_h [0:HIST-1];

   dpd_loop_delay_est #(
      .LAG_MIN   (LAG_MIN),
      .LAG_MAX   (LAG_MAX),
      .WIN_START (WS),
      .WIN       (WN),
      .GAP       (GP)
   ) dut (
      .clk         (clk),
      .reset_b     (reset_b),
      .start       (start),
      .abort       (abort),
      .ref_i       (ref_i),
      .ref_q       (ref_q),
      .fb_i        (fb_i),
      .fb_q        (fb_q),
      .train_req   (train_req),
      .busy        (busy),
      .done        (done),
      .delay_out   (delay_out),
      .delay_valid (delay_valid),
      .peak_metric (peak_metric)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt++;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One cycle: sample outputs at the falling edge, then drive inputs for the next rising edge.
   task automatic applyStimulus(input logic st, input logic ab);
      int n;
      @(negedge clk);
      if (train_req) treq_cnt++;
      n = edge_cnt;
      if (n >= HIST) begin
         $display("[TB] FAIL history_overflow: observed %0d expected below %0d", n, HIST);
         $fatal(1, "[TB] history exhausted");
      end
      ri_h[n] = ($urandom_range(1, 0) == 1) ? AMP : -AMP;
      rq_h[n] = ($urandom_range(1, 0) == 1) ? AMP : -AMP;
      if (gen_delay >= 0 && n >= gen_delay) begin
         fi_h[n] = ri_h[n - gen_delay];
         fq_h[n] = rq_h[n - gen_delay];
      end else begin
         fi_h[n] = 0;
         fq_h[n] = 0;
      end
      ref_i = 20'(ri_h[n]);
      ref_q = 20'(rq_h[n]);
      fb_i  = 20'(fi_h[n]);
      fb_q  = 20'(fq_h[n]);
      start = st;
      abort = ab;
   endtask

   // Lag k's burst is requested at edge es+k*PER; window sample c lands on edge es+k*PER+2+c.
   task automatic modelSearch(input int es, output int blag, output longint bmet);
      longint acc, p;
      int     t, lagv;
      blag = LAG_MIN;
      bmet = 0;
      for (int k = 0; k < NLAG; k++) begin
         lagv = LAG_MIN + k;
         acc  = 0;
         for (int c = WS; c < WS + WN; c++) begin
            t    = es + k * PER + 2 + c;
            p    = longint'(ri_h[t - lagv]) * fi_h[t] + longint'(rq_h[t - lagv]) * fq_h[t];
            acc += p >>> 8;
         end
         if (k == 0 || acc > bmet) begin
            bmet = acc;
            blag = lagv;
         end
      end
   endtask

   task automatic runSearch(input string tag, input int dly, input int extra_start_at, output int got_lag);
      int          es, blag, done_edge;
      longint      bmet;
      logic [47:0] bmet48;
      gen_delay = dly;
      applyStimulus(1'b1, 1'b0);
      es        = edge_cnt;
      treq_cnt  = 0;
      done_edge = -1;
      for (int i = 1; i <= NLAG * PER + 20 && done_edge < 0; i++) begin
         applyStimulus(i == extra_start_at, 1'b0);
         if (done) done_edge = edge_cnt - 1;
      end
      checkOutput({tag, "_done_time"}, 64'(done_edge), 64'(es + NLAG * PER));
      checkOutput({tag, "_valid"}, 64'(delay_valid), 64'd1);
      checkOutput({tag, "_busy_in_done"}, 64'(busy), 64'd1);
      checkOutput({tag, "_train_reqs"}, 64'(treq_cnt), 64'(NLAG));
      modelSearch(es, blag, bmet);
      bmet48 = 48'(bmet);
      checkOutput({tag, "_delay_model"}, 64'(delay_out), 64'(blag));
      checkOutput({tag, "_peak_model"}, {16'd0, peak_metric}, {16'd0, bmet48});
      applyStimulus(1'b0, 1'b0);
      checkOutput({tag, "_done_pulse"}, 64'(done), 64'd0);
      checkOutput({tag, "_busy_after"}, 64'(busy), 64'd0);
      checkOutput({tag, "_valid_hold"}, 64'(delay_valid), 64'd1);
      got_lag = int'(delay_out);
   endtask

   initial begin
      int got, es, seen_done;
      reset_b = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      ref_i   = '0;
      ref_q   = '0;
      fb_i    = '0;
      fb_q    = '0;
      repeat (3) applyStimulus(1'b0, 1'b0);
      checkOutput("rst_train_req", 64'(train_req), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_valid", 64'(delay_valid), 64'd0);
      checkOutput("rst_delay", 64'(delay_out), 64'd0);
      checkOutput("rst_peak", {16'd0, peak_metric}, 64'd0);
      reset_b = 1'b1;
      repeat (3) applyStimulus(1'b0, 1'b0);

      $display("[TB] search with feedback delayed 41");
      runSearch("d41", 41, 0, got);
      checkOutput("d41_delay", 64'(got), 64'd41);
      checkOutput("d41_peak_pos", 64'(peak_metric > 0), 64'd1);

      $display("[TB] search with zero feedback");
      runSearch("zero", -1, 0, got);
      checkOutput("zero_delay", 64'(got), 64'(LAG_MIN));
      checkOutput("zero_peak", {16'd0, peak_metric}, 64'd0);

      $display("[TB] boundary lags");
      runSearch("d63", 63, 0, got);
      checkOutput("d63_delay", 64'(got), 64'd63);
      runSearch("d16", 16, 0, got);
      checkOutput("d16_delay", 64'(got), 64'd16);

      $display("[TB] start while busy");
      runSearch("restart", 25, 100, got);
      checkOutput("restart_delay", 64'(got), 64'd25);

      $display("[TB] abort during lag 30");
      gen_delay = 50;
      applyStimulus(1'b1, 1'b0);
      repeat (14 * PER + 20) applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0);
      checkOutput("abort_busy", 64'(busy), 64'd0);
      checkOutput("abort_done", 64'(done), 64'd0);
      checkOutput("abort_valid", 64'(delay_valid), 64'd0);
      checkOutput("abort_train_req", 64'(train_req), 64'd0);
      checkOutput("abort_delay_hold", 64'(delay_out), 64'd25);
      seen_done = 0;
      repeat (2 * PER) begin
         applyStimulus(1'b0, 1'b0);
         if (done || busy || train_req) seen_done = 1;
      end
      checkOutput("abort_stays_idle", 64'(seen_done), 64'd0);
      runSearch("post_abort", 50, 0, got);
      checkOutput("post_abort_delay", 64'(got), 64'd50);

      $display("[TB] reset during gap");
      gen_delay = 41;
      applyStimulus(1'b1, 1'b0);
      es = edge_cnt;
      repeat (3 * PER + 100) applyStimulus(1'b0, 1'b0);
      checkOutput("pre_reset_busy", 64'(busy), 64'd1);
      reset_b = 1'b0;
      #1;
      checkOutput("mid_rst_busy", 64'(busy), 64'd0);
      checkOutput("mid_rst_train_req", 64'(train_req), 64'd0);
      checkOutput("mid_rst_done", 64'(done), 64'd0);
      checkOutput("mid_rst_valid", 64'(delay_valid), 64'd0);
      checkOutput("mid_rst_delay", 64'(delay_out), 64'd0);
      checkOutput("mid_rst_peak", {16'd0, peak_metric}, 64'd0);
      repeat (2) applyStimulus(1'b0, 1'b0);
      reset_b = 1'b1;
      repeat (2) applyStimulus(1'b0, 1'b0);
      runSearch("post_reset", 41, 0, got);
      checkOutput("post_reset_delay", 64'(got), 64'd41);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
